amns_mm_sequencer: RTL and testbench
====================================

// Module: amns_mm_sequencer
// PURPOSE
//  Top-level operation sequencer for the AMNS modular multiplier. On a host start it runs three phases in order:
//  - load: pulses the memory controller's load start and waits for its load done;
//  - multiply: pulses the multiplier datapath start and waits for its done;
//  - store: pulses the memory controller's store start and waits for its store done.
//  It then reports completion. A per-phase watchdog traps a hung phase in an error state.
// PARAMETERS
//  WORD_WIDTH    17         DSP word width (pass-through, keeps parameter set uniform)
//  N             5          coefficients per AMNS polynomial
//  S             4          WORD_WIDTH blocks per coefficient
//  TIMEOUT       16*N*S     max cycles allowed in any *_WAIT state (=320)
//  OP_CNT_WIDTH  16         width of completed-operation counter
// PORTS
//  clock_i          in   1             single clock, rising edge
//  reset_i          in   1             asynchronous, active-high reset
//  start_i          in   1             host request, sampled only in IDLE
//  err_clear_i      in   1             leaves ERROR, sampled only in ERROR
//  load_done_i      in   1             from memory controller load_done_o
//  mult_done_i      in   1             from multiplier datapath
//  store_done_i     in   1             from memory controller store_done_o
//  load_start_o     out  1             to memory controller load_start_i
//  mult_start_o     out  1             to multiplier start
//  store_start_o    out  1             to memory controller store_start_i
//  busy_o           out  1             operation in progress
//  done_o           out  1             one-cycle completion pulse
//  error_o          out  1             watchdog expired, held until cleared
//  op_count_o       out  OP_CNT_WIDTH  completed operations, wraps modulo 2^OP_CNT_WIDTH
// BEHAVIOUR
//  FSM register current_state, 4 bits. Encodings:
//    RESET=0, IDLE=1, LOAD=2, LOAD_WAIT=3, MULT=4, MULT_WAIT=5, STORE=6, STORE_WAIT=7, DONE=8, ERROR=9.
//  Reset:
//  - reset_i high: current_state=RESET immediately; all outputs 0; op_count_o=0; watchdog=0.
//  - First rising edge with reset_i low: RESET->IDLE.
//  - Reset mid-operation aborts without any done/error pulse.
//  Transitions (evaluated at rising edge):
//  - IDLE: start_i=1 -> LOAD, else stay.
//  - LOAD -> LOAD_WAIT; MULT -> MULT_WAIT; STORE -> STORE_WAIT (one cycle each, unconditional).
//  - LOAD_WAIT: load_done_i -> MULT. MULT_WAIT: mult_done_i -> STORE. STORE_WAIT: store_done_i -> DONE.
//  - DONE -> IDLE; op_count_o increments by 1 on this edge.
//  - ERROR: err_clear_i=1 -> IDLE, else stay.
//  Outputs are Moore decodes of current_state:
//  - load_start_o=1 iff LOAD; mult_start_o=1 iff MULT; store_start_o=1 iff STORE.
//    Each start is therefore exactly one cycle wide.
//  - busy_o=1 in LOAD..STORE_WAIT and DONE; 0 in RESET, IDLE, ERROR.
//  - done_o=1 iff DONE; error_o=1 iff ERROR.
//  Latency: start_i seen at edge k gives load_start_o high in cycle k+1.
//    Minimum start-to-done_o is 7 cycles, when each done arrives the first cycle of its WAIT state.
//  Watchdog:
//  - Counter is cleared on entry to each *_WAIT state and increments each cycle while in it.
//  - When the counter equals TIMEOUT-1 and the awaited done is low -> ERROR.
//  - If the awaited done is high in that same cycle, done wins (normal transition).
//  Ignored inputs:
//  - start_i outside IDLE (including during DONE) is ignored; no queueing.
//  - Done inputs outside their own WAIT state are ignored (stale or early pulses have no effect).
//  - err_clear_i outside ERROR is ignored.
//  op_count_o does not increment on ERROR or abort. At 2^OP_CNT_WIDTH-1 the next DONE wraps it to 0.
// TESTING
//  1. reset_i=1 mid-MULT_WAIT -> same cycle: current_state=RESET, all outputs 0; one edge after release: IDLE.
//  2. start_i=1 one cycle; done inputs returned after 3, 5, 2 WAIT cycles
//     -> single-cycle load_start_o, mult_start_o, store_start_o; done_o high one cycle; op_count_o 0->1; busy_o low after.
//  3. Fast path, each done high the first WAIT cycle -> done_o exactly 7 cycles after start_i sampled.
//  4. Hold mult_done_i=0 -> ERROR after 320 MULT_WAIT cycles, error_o=1, busy_o=0, op_count_o unchanged;
//     err_clear_i=1 -> IDLE, error_o=0.
//  5. store_done_i=1 exactly on watchdog cycle 319 -> DONE, not ERROR.
//  6. Stray load_done_i pulse in IDLE and start_i during DONE -> no state change; second op needs fresh start_i.

Source files
------------

// File: rtl/amns_mm_sequencer.sv
// rtl/amns_mm_sequencer.sv - load/multiply/store operation sequencer for the AMNS modular multiplier
//
// Ports:
//   clock_i, reset_i          single rising-edge clock, asynchronous active-high reset
//   start_i                   host request, acted on only in IDLE
//   err_clear_i               leaves ERROR, acted on only in ERROR
//   load_done_i               memory controller load completion
//   mult_done_i               multiplier datapath completion
//   store_done_i              memory controller store completion
//   load_start_o              one-cycle load kick to the memory controller
//   mult_start_o              one-cycle kick to the multiplier datapath
//   store_start_o             one-cycle store kick to the memory controller
//   busy_o                    operation in progress (LOAD..STORE_WAIT, DONE)
//   done_o                    one-cycle completion pulse
//   error_o                   watchdog expired, held until err_clear_i
//   op_count_o                completed operations, wraps modulo 2^OP_CNT_WIDTH

module amns_mm_sequencer #(
    parameter int WORD_WIDTH   = 17,
    parameter int N            = 5,
    parameter int S            = 4,
    parameter int TIMEOUT      = 16 * N * S,
    parameter int OP_CNT_WIDTH = 16
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic                    err_clear_i,
    input  logic                    load_done_i,
    input  logic                    mult_done_i,
    input  logic                    store_done_i,
    output logic                    load_start_o,
    output logic                    mult_start_o,
    output logic                    store_start_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [OP_CNT_WIDTH-1:0] op_count_o
);

    // WORD_WIDTH only travels with the shared parameter set; reject nonsense values.
    if (WORD_WIDTH < 1 || N < 1 || S < 1 || TIMEOUT < 2) begin : g_bad_params
        $error("amns_mm_sequencer: invalid parameter set");
    end

    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        RESET      = 4'd0,
        IDLE       = 4'd1,
        LOAD       = 4'd2,
        LOAD_WAIT  = 4'd3,
        MULT       = 4'd4,
        MULT_WAIT  = 4'd5,
        STORE      = 4'd6,
        STORE_WAIT = 4'd7,
        DONE       = 4'd8,
        ERROR      = 4'd9
    } state_t;

    state_t          current_state;
    state_t          next_state;
    logic [WD_W-1:0] watchdog;
    logic            wd_expired;

    assign wd_expired = (watchdog == WD_LAST);

    // In each WAIT state the awaited done is checked before the watchdog,
    // so a done arriving on the final watchdog cycle still completes normally.
    always_comb begin
        next_state = current_state;
        case (current_state)
            RESET:      next_state = IDLE;
            IDLE:       next_state = start_i ? LOAD : IDLE;
            LOAD:       next_state = LOAD_WAIT;
            LOAD_WAIT: begin
                if (load_done_i)     next_state = MULT;
                else if (wd_expired) next_state = ERROR;
            end
            MULT:       next_state = MULT_WAIT;
            MULT_WAIT: begin
                if (mult_done_i)     next_state = STORE;
                else if (wd_expired) next_state = ERROR;
            end
            STORE:      next_state = STORE_WAIT;
            STORE_WAIT: begin
                if (store_done_i)    next_state = DONE;
                else if (wd_expired) next_state = ERROR;
            end
            DONE:       next_state = IDLE;
            ERROR:      next_state = err_clear_i ? IDLE : ERROR;
            default:    next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up exactly with
    // current_state, giving glitch-free Moore outputs.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            current_state <= RESET;
            watchdog      <= '0;
            op_count_o    <= '0;
            load_start_o  <= 1'b0;
            mult_start_o  <= 1'b0;
            store_start_o <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            current_state <= next_state;

            // Any state change clears the watchdog, which covers entry into
            // each WAIT state; it only advances while a WAIT state persists.
            if (next_state != current_state) begin
                watchdog <= '0;
            end else if (current_state == LOAD_WAIT ||
                         current_state == MULT_WAIT ||
                         current_state == STORE_WAIT) begin
                watchdog <= watchdog + 1'b1;
            end

            if (current_state == DONE) begin
                op_count_o <= op_count_o + 1'b1;
            end

            load_start_o  <= (next_state == LOAD);
            mult_start_o  <= (next_state == MULT);
            store_start_o <= (next_state == STORE);
            done_o        <= (next_state == DONE);
            error_o       <= (next_state == ERROR);
            busy_o        <= (next_state == LOAD)  || (next_state == LOAD_WAIT)  ||
                             (next_state == MULT)  || (next_state == MULT_WAIT)  ||
                             (next_state == STORE) || (next_state == STORE_WAIT) ||
                             (next_state == DONE);
        end
    end

endmodule

// File: tb/tb_amns_mm_sequencer.sv
// tb/tb_amns_mm_sequencer.sv - directed self-checking bench for amns_mm_sequencer

module tb_amns_mm_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic        err_clear;
    logic        load_done;
    logic        mult_done;
    logic        store_done;
    logic        load_start;
    logic        mult_start;
    logic        store_start;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] op_count;

    logic        w_load_start;
    logic        w_mult_start;
    logic        w_store_start;
    logic        w_busy;
    logic        w_done;
    logic        w_error;
    logic [1:0]  w_op_count;

    int checks;
    int errors;
    int n;

    amns_mm_sequencer dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .start_i      (start),
        .err_clear_i  (err_clear),
        .load_done_i  (load_done),
        .mult_done_i  (mult_done),
        .store_done_i (store_done),
        .load_start_o (load_start),
        .mult_start_o (mult_start),
        .store_start_o(store_start),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .op_count_o   (op_count)
    );

    // Narrow-counter twin on the same inputs, used to observe the wrap.
    amns_mm_sequencer #(.OP_CNT_WIDTH(2)) dut_wrap (
        .clock_i      (clock),
        .reset_i      (reset),
        .start_i      (start),
        .err_clear_i  (err_clear),
        .load_done_i  (load_done),
        .mult_done_i  (mult_done),
        .store_done_i (store_done),
        .load_start_o (w_load_start),
        .mult_start_o (w_mult_start),
        .store_start_o(w_store_start),
        .busy_o       (w_busy),
        .done_o       (w_done),
        .error_o      (w_error),
        .op_count_o   (w_op_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // outputs packed as {load_start, mult_start, store_start, busy, done, error}
    function automatic logic [5:0] outs();
        return {load_start, mult_start, store_start, busy, done, error};
    endfunction

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        start      = 1'b0;
        err_clear  = 1'b0;
        load_done  = 1'b0;
        mult_done  = 1'b0;
        store_done = 1'b0;

        // Reset state and release
        tick();
        chk("reset_state", 32'(dut.current_state), 32'd0);
        chk("reset_outs", 32'(outs()), 32'd0);
        chk("reset_count", 32'(op_count), 32'd0);
        reset = 1'b0;
        tick();
        chk("release_idle", 32'(dut.current_state), 32'd1);

        // Normal op, dones after 3, 5, 2 WAIT cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("op1_load", 32'(dut.current_state), 32'd2);
        chk("op1_load_outs", 32'(outs()), 32'b100100);
        tick();
        chk("op1_load_pulse", 32'(outs()), 32'b000100);
        chk("op1_load_wait", 32'(dut.current_state), 32'd3);
        tick(); tick();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        chk("op1_mult_outs", 32'(outs()), 32'b010100);
        tick();
        chk("op1_mult_wait", 32'(dut.current_state), 32'd5);
        chk("op1_mult_pulse", 32'(outs()), 32'b000100);
        for (int i = 0; i < 4; i++) tick();
        mult_done = 1'b1;
        tick();
        mult_done = 1'b0;
        chk("op1_store_outs", 32'(outs()), 32'b001100);
        tick();
        chk("op1_store_wait", 32'(dut.current_state), 32'd7);
        tick();
        store_done = 1'b1;
        tick();
        store_done = 1'b0;
        chk("op1_done_outs", 32'(outs()), 32'b000110);
        chk("op1_count_in_done", 32'(op_count), 32'd0);
        tick();
        chk("op1_idle_outs", 32'(outs()), 32'b000000);
        chk("op1_count", 32'(op_count), 32'd1);

        // Fast path: all dones held high, done_o 7 edges after start sampled
        load_done  = 1'b1;
        mult_done  = 1'b1;
        store_done = 1'b1;
        start      = 1'b1;
        n = 0;
        while (!done && n < 50) begin
            tick();
            start = 1'b0;
            n++;
        end
        chk("fast_latency", 32'(n), 32'd7);
        load_done  = 1'b0;
        mult_done  = 1'b0;
        store_done = 1'b0;
        tick();
        chk("fast_count", 32'(op_count), 32'd2);

        // Watchdog expiry in MULT_WAIT
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        tick();
        chk("wd_enter_mult_wait", 32'(dut.current_state), 32'd5);
        for (int i = 0; i < 319; i++) tick();
        chk("wd_still_waiting", 32'(dut.current_state), 32'd5);
        tick();
        chk("wd_error_state", 32'(dut.current_state), 32'd9);
        chk("wd_error_outs", 32'(outs()), 32'b000001);
        chk("wd_count_kept", 32'(op_count), 32'd2);
        start = 1'b1;
        tick(); tick();
        start = 1'b0;
        chk("wd_error_held", 32'(dut.current_state), 32'd9);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("wd_clear_idle", 32'(dut.current_state), 32'd1);
        chk("wd_clear_outs", 32'(outs()), 32'b000000);

        // Store done on the final watchdog cycle wins over the watchdog
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        tick();
        mult_done = 1'b1;
        tick();
        mult_done = 1'b0;
        tick();
        chk("race_enter_store_wait", 32'(dut.current_state), 32'd7);
        for (int i = 0; i < 319; i++) tick();
        store_done = 1'b1;
        tick();
        store_done = 1'b0;
        chk("race_done_state", 32'(dut.current_state), 32'd8);
        chk("race_done_outs", 32'(outs()), 32'b000110);
        tick();
        chk("race_count", 32'(op_count), 32'd3);
        chk("wrap_count3", 32'(w_op_count), 32'd3);

        // Stray done in IDLE, start during DONE ignored
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        chk("stray_idle", 32'(dut.current_state), 32'd1);
        chk("stray_outs", 32'(outs()), 32'b000000);
        start = 1'b1;
        tick();
        start = 1'b0;
        load_done  = 1'b1;
        mult_done  = 1'b1;
        store_done = 1'b1;
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        chk("op4_reached_done", 32'(done), 32'd1);
        load_done  = 1'b0;
        mult_done  = 1'b0;
        store_done = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("op4_idle", 32'(dut.current_state), 32'd1);
        chk("op4_count", 32'(op_count), 32'd4);
        chk("wrap_count0", 32'(w_op_count), 32'd0);
        tick();
        chk("no_queue_idle", 32'(dut.current_state), 32'd1);
        chk("no_queue_outs", 32'(outs()), 32'b000000);

        // Asynchronous reset mid-MULT_WAIT
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        tick(); tick();
        chk("abort_in_mult_wait", 32'(dut.current_state), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_state", 32'(dut.current_state), 32'd0);
        chk("abort_outs", 32'(outs()), 32'd0);
        chk("abort_count", 32'(op_count), 32'd0);
        #2;
        reset = 1'b0;
        tick();
        chk("abort_release_idle", 32'(dut.current_state), 32'd1);
        chk("abort_release_outs", 32'(outs()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
